// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter slice.
//   DIR_UP / DIR_DOWN    : encodings of the Ud direction input
//   CNT_*_DEF            : default WIDTH / MOD / PRESCALE values
//   clamp_load(din, mod) : load value saturated to mod-1 when din >= mod
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned CNT_WIDTH_DEF    = 4;
  localparam int unsigned CNT_MOD_DEF      = 16;
  localparam int unsigned CNT_PRESCALE_DEF = 10;

  function automatic logic [31:0] clamp_load(input logic [31:0] din, input logic [31:0] mod);
    return (din < mod) ? din : (mod - 32'd1);
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of mod_updown_counter.
//   En   : count enable            Ud   : direction (1 = up, 0 = down)
//   Ld   : synchronous load strobe din  : load value
//   cnt  : registered count        tc   : terminal count (combinational)
//   wrap : one-cycle pulse after a wrapping step
// master drives the controls (bench / parent), slave is the counter.
interface mod_updown_counter_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
);

  logic             En;
  logic             Ud;
  logic             Ld;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;

  modport master (
    output En, Ud, Ld, din,
    input  cnt, tc, wrap
  );

  modport slave (
    input  En, Ud, Ld, din,
    output cnt, tc, wrap
  );

endinterface

// File: rtl/tick_gen.sv
// Count-tick prescaler: free-running modulo-DIV phase counter that advances
// only while En=1. tick is high for the one cycle in DIV where the phase sits
// at DIV-1, so the first tick after reset falls DIV cycles after release.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset (phase -> 0)
//   En   : advance enable; phase holds while low
//   tick : one-in-DIV enable pulse
module tick_gen
  import counter_pkg::*;
#(
  parameter int unsigned DIV = CNT_PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic En,
  output logic tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (En) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tick = (phase_q == LAST);

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter that counts modulo MOD, with synchronous clamped load,
// terminal count and a registered wrap pulse.
// Build option: define COUNTER_PRESCALE_EN to gate count steps with a
// divide-by-PRESCALE tick (tick_gen); otherwise every enabled cycle steps and
// PRESCALE is unused.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset (cnt=0, wrap=0, prescaler phase=0)
//   bus : slave side of mod_updown_counter_if (En, Ud, Ld, din -> cnt, tc, wrap)
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = CNT_WIDTH_DEF,
  parameter int unsigned MOD      = CNT_MOD_DEF,
  parameter int unsigned PRESCALE = CNT_PRESCALE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_updown_counter_if.slave  bus
);

  // Next-count arithmetic is one bit wider than the register so that a
  // modulus of 2**WIDTH is recognised as a wrap rather than aliasing to zero.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);

  logic             tick;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH:0]   up_ext;
  logic [WIDTH:0]   dn_ext;
  logic             up_wrap;
  logic             dn_wrap;
  logic [WIDTH-1:0] ld_val;

`ifdef COUNTER_PRESCALE_EN
  tick_gen #(
    .DIV (PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .En   (bus.En),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    up_ext  = {1'b0, cnt_q} + (WIDTH + 1)'(1);
    dn_ext  = {1'b0, cnt_q} - (WIDTH + 1)'(1);
    up_wrap = (up_ext == MOD_EXT);
    dn_wrap = dn_ext[WIDTH];  // borrow out of zero
    ld_val  = WIDTH'(clamp_load(32'(bus.din), 32'(MOD)));

    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.Ld) begin
      cnt_d = ld_val;
    end else if (bus.En && tick) begin
      // Ud is only looked at here, on the stepping edge.
      if (bus.Ud == DIR_UP) begin
        cnt_d  = up_wrap ? '0 : up_ext[WIDTH-1:0];
        wrap_d = up_wrap;
      end else begin
        cnt_d  = dn_wrap ? MAX_CNT : dn_ext[WIDTH-1:0];
        wrap_d = dn_wrap;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = bus.En && (((bus.Ud == DIR_UP) && (cnt_q == MAX_CNT)) ||
                               ((bus.Ud == DIR_DOWN) && (cnt_q == '0)));

  param_ok_a: assert property (@(posedge clk) disable iff (rst)
    (MOD >= 2) && (MOD <= (2 ** WIDTH)) && (PRESCALE >= 1) && ($bits(bus.cnt) == WIDTH));

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(4)) if10 ();
  mod_updown_counter_if #(.WIDTH(4)) if16 ();

  mod_updown_counter #(
    .WIDTH    (4),
    .MOD      (10),
    .PRESCALE (10)
  ) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (if10.slave)
  );

  mod_updown_counter #(
    .WIDTH    (4),
    .MOD      (16),
    .PRESCALE (10)
  ) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       en;
    logic       ud;
    logic       ld;
    logic [3:0] din;
    logic [3:0] cnt;
    logic       tc;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic ud, input logic ld, input logic [3:0] din,
                     input logic [3:0] cnt, input logic tc, input logic wrap);
    vec_t v;
    v.en = en; v.ud = ud; v.ld = ld; v.din = din;
    v.cnt = cnt; v.tc = tc; v.wrap = wrap;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if10.En = 1'b1; if10.Ud = 1'b0; if10.Ld = 1'b0; if10.din = 4'd0;
    if16.En = 1'b0; if16.Ud = 1'b1; if16.Ld = 1'b0; if16.din = 4'd0;
    #2;
    check("reset cnt10", 32'(if10.cnt), 0);
    check("reset wrap10", 32'(if10.wrap), 0);
    check("reset tc10 down", 32'(if10.tc), 1);
    check("reset cnt16", 32'(if16.cnt), 0);
    check("reset tc16 disabled", 32'(if16.tc), 0);
    if10.Ud = 1'b1;
    #1;
    check("reset tc10 up", 32'(if10.tc), 0);

`ifdef COUNTER_PRESCALE_EN
    @(negedge clk);
    rst = 1'b0;
    if10.En = 1'b1; if10.Ud = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("pre 9 edges", 32'(if10.cnt), 0);
    step();
    check("pre 10 edges", 32'(if10.cnt), 1);
    for (int i = 0; i < 9; i++) step();
    check("pre 19 edges", 32'(if10.cnt), 1);
    step();
    check("pre 20 edges", 32'(if10.cnt), 2);
    if10.En = 1'b0;
    for (int i = 0; i < 25; i++) step();
    check("pre frozen cnt", 32'(if10.cnt), 2);
    if10.En = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("pre phase held", 32'(if10.cnt), 2);
    step();
    check("pre resume", 32'(if10.cnt), 3);
    check("pre wrap", 32'(if10.wrap), 0);
`else
    // Vectors for the modulus-10 instance: inputs applied for one edge, then
    // cnt/tc/wrap compared.
    for (int i = 1; i <= 9; i++) add(1, 1, 0, 4'd0, 4'(i), (i == 9), 0);
    add(1, 1, 0, 4'd0,  4'd0, 0, 1);  // 9 -> 0 wraps
    add(1, 1, 0, 4'd0,  4'd1, 0, 0);
    add(1, 0, 1, 4'd2,  4'd2, 0, 0);  // load 2, then count down
    add(1, 0, 0, 4'd0,  4'd1, 0, 0);
    add(1, 0, 0, 4'd0,  4'd0, 1, 0);
    add(1, 0, 0, 4'd0,  4'd9, 0, 1);  // 0 -> 9 wraps
    add(1, 0, 0, 4'd0,  4'd8, 0, 0);
    add(1, 1, 1, 4'd13, 4'd9, 1, 0);  // clamped load, no wrap
    add(1, 1, 1, 4'd4,  4'd4, 0, 0);
    add(0, 1, 0, 4'd0,  4'd4, 0, 0);  // hold
    add(0, 1, 1, 4'd10, 4'd9, 0, 0);  // din == MOD clamps, load ignores En
    add(1, 1, 0, 4'd0,  4'd0, 0, 1);
    add(0, 1, 0, 4'd0,  4'd0, 0, 0);  // wrap drops while disabled
    add(0, 0, 0, 4'd0,  4'd0, 0, 0);
    add(1, 0, 0, 4'd0,  4'd9, 0, 1);
    add(1, 1, 1, 4'd15, 4'd9, 1, 0);  // load beats a wrapping step

    @(negedge clk);
    if10.En = 1'b0;
    rst = 1'b0;
    foreach (vecs[i]) begin
      if10.En = vecs[i].en; if10.Ud = vecs[i].ud;
      if10.Ld = vecs[i].ld; if10.din = vecs[i].din;
      step();
      check($sformatf("vec%0d cnt", i), 32'(if10.cnt), 32'(vecs[i].cnt));
      check($sformatf("vec%0d tc", i), 32'(if10.tc), 32'(vecs[i].tc));
      check($sformatf("vec%0d wrap", i), 32'(if10.wrap), 32'(vecs[i].wrap));
    end

    // Asynchronous reset in the middle of a cycle.
    if10.En = 1'b0; if10.Ld = 1'b1; if10.din = 4'd7;
    step();
    check("load 7", 32'(if10.cnt), 7);
    if10.Ld = 1'b0; if10.En = 1'b1; if10.Ud = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async rst cnt", 32'(if10.cnt), 0);
    check("async rst wrap", 32'(if10.wrap), 0);
    @(negedge clk);
    check("rst held cnt", 32'(if10.cnt), 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("post rst %0d", i), 32'(if10.cnt), 32'(i));
    end
    if10.En = 1'b0;

    // Modulus-16 instance: direction flips every cycle across the wrap point.
    if16.Ld = 1'b1; if16.din = 4'd15;
    step();
    check("m16 load 15", 32'(if16.cnt), 15);
    if16.Ld = 1'b0; if16.En = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if16.Ud = (k % 2 == 0);
      step();
      check($sformatf("m16 toggle%0d cnt", k), 32'(if16.cnt), (k % 2 == 0) ? 0 : 15);
      check($sformatf("m16 toggle%0d wrap", k), 32'(if16.wrap), 1);
    end
    if16.En = 1'b0;
    step();
    check("m16 idle cnt", 32'(if16.cnt), 15);
    check("m16 idle wrap", 32'(if16.wrap), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter register width in bits.
REQ-002 SHALL have parameter MOD, default 16: count modulus; legal range 2..2**WIDTH; count sequence is 0..MOD-1.
REQ-003 SHALL have parameter PRESCALE, default 10: clock cycles per count tick; used only when the prescaler is compiled in.
REQ-004 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port En, input, 1 bit: count enable.
REQ-007 SHALL have port Ud, input, 1 bit: direction; 1 = up, 0 = down.
REQ-008 SHALL have port Ld, input, 1 bit: synchronous parallel load strobe.
REQ-009 SHALL have port din, input, WIDTH bits: load value.
REQ-010 SHALL have port cnt, output, WIDTH bits: registered count value.
REQ-011 SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-012 SHALL have port wrap, output, 1 bit: registered one-cycle pulse flagging that a wrap has occurred.

Function
REQ-013 SHALL define tick as 1 on every cycle when the prescaler is compiled out; otherwise tick SHALL be 1 for one cycle in every PRESCALE cycles.
REQ-014 SHALL apply this priority at each rising clk edge: Ld first, then (En && tick), then hold.
REQ-015 SHALL, on Ld, set cnt to din when din < MOD and to MOD-1 when din >= MOD; Ld SHALL ignore En and tick, SHALL NOT assert wrap, and SHALL NOT reset the prescaler.
REQ-016 SHALL, on an up count step (Ud=1), set cnt to cnt+1, or to 0 when cnt == MOD-1.
REQ-017 SHALL, on a down count step (Ud=0), set cnt to cnt-1, or to MOD-1 when cnt == 0.
REQ-018 SHALL latency-sample Ud on the stepping edge only: a direction change takes effect at the next step with no extra cycle and no glitch step.
REQ-019 SHALL drive tc = En && ((Ud && cnt==MOD-1) || (!Ud && cnt==0)); tc is independent of tick.
REQ-020 SHALL drive wrap high for exactly one clk cycle following any step that wraps, i.e. MOD-1->0 or 0->MOD-1.
REQ-021 SHALL hold cnt and the prescaler phase while En=0; wrap SHALL deassert on the next edge.
REQ-022 SHALL compute all next-count values at WIDTH+1 bits internally so that MOD = 2**WIDTH wraps correctly with no overflow alias.

Reset
REQ-023 SHALL, while rst=1 and independent of clk, force cnt=0, wrap=0 and prescaler counter=0.
REQ-024 SHALL override any count or load that is in progress when rst asserts; on the first edge after rst deasserts, Ld and En SHALL be honoured, and the first tick with the prescaler compiled in SHALL occur PRESCALE cycles after deassertion.
REQ-025 SHALL drive tc from the reset cnt value, so tc = En && !Ud during reset.

Configuration
REQ-026 SHALL, when macro COUNTER_PRESCALE_EN is defined, instantiate the tick prescaler of REQ-013 with division by PRESCALE.
REQ-027 SHALL, when COUNTER_PRESCALE_EN is undefined, tie tick to 1, omit all prescaler logic, and leave PRESCALE unused.

Structure
REQ-028 SHALL place in shared package counter_pkg: constants DIR_UP=1'b1 and DIR_DOWN=1'b0, default constants CNT_WIDTH_DEF=4, CNT_MOD_DEF=16 and CNT_PRESCALE_DEF=10, and a function clamp_load(din, mod).
REQ-029 SHALL implement the prescaler as sub-module tick_gen with ports clk, rst, En, tick and parameter DIV; it SHALL be a free-running modulo-DIV counter that advances only while En=1.

Verification
REQ-030 SHALL cover: WIDTH=4, MOD=10, prescaler off, En=1, Ud=1 from reset -> cnt 0..9 then 0; wrap high for exactly the cycle after 9->0; tc high while cnt=9.
REQ-031 SHALL cover: MOD=10, Ud=0 from cnt=2 -> 2,1,0,9,8; tc high at cnt=0; one wrap pulse after 0->9.
REQ-032 SHALL cover: Ld=1 with din=13, MOD=10, En=1 -> cnt=9 next cycle and no wrap; then Ld=1 with din=4 -> cnt=4.
REQ-033 SHALL cover: rst asserted mid-cycle at cnt=7 -> cnt=0 immediately, before the next clk edge; after release with En=1, Ud=1 -> cnt 1,2,3.
REQ-034 SHALL cover: COUNTER_PRESCALE_EN defined, PRESCALE=10, En=1, Ud=1 -> cnt increments every 10 clk cycles; En=0 for 25 cycles -> cnt and phase frozen.
REQ-035 SHALL cover: WIDTH=4, MOD=16, Ud toggled each cycle starting at cnt=15 -> 15->0 (wrap), 0->15 (wrap), alternating, with no missed or extra step.
